alu_arbiter: RTL

- Shares the single registered 8-bit ALU between two requesters (e.g. instruction-execute path and address/loop unit).
- Round-robin arbitration with a valid/ready request handshake on each requester.
- Sequences one operation at a time: issues a one-cycle alu_en pulse, waits for the registered result, then returns the result and flags on a shared response channel tagged with the requester id.

---
 rtl/alu_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one registered ALU between two requesters.
// Define ALU_ARB_STATS_EN to add the op_cnt / stall_cnt statistics ports.
module alu_arbiter #(
   parameter int ALU_LAT = 1,
   parameter int DW      = 8,
   parameter int OPW     = 3
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           req0_valid,
   output logic           req0_ready,
   input  logic [DW-1:0]  req0_a,
   input  logic [DW-1:0]  req0_b,
   input  logic [OPW-1:0] req0_op,
   input  logic           req1_valid,
   output logic           req1_ready,
   input  logic [DW-1:0]  req1_a,
   input  logic [DW-1:0]  req1_b,
   input  logic [OPW-1:0] req1_op,
   output logic           resp_valid,
   input  logic           resp_ready,
   output logic           resp_id,
   output logic [DW-1:0]  resp_res,
   output logic [2:0]     resp_flags,
   output logic [DW-1:0]  alu_a,
   output logic [DW-1:0]  alu_b,
   output logic [OPW-1:0] alu_op,
   output logic           alu_en,
   input  logic [DW-1:0]  alu_res,
   input  logic           alu_c_out,
   input  logic           alu_zero,
   input  logic           alu_ovf,
   output logic           busy
`ifdef ALU_ARB_STATS_EN
   ,
   output logic [15:0]    op_cnt,
   output logic [15:0]    stall_cnt
`endif
);

   localparam int CW = 4;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   typedef struct packed {
      logic [DW-1:0]  a;
      logic [DW-1:0]  b;
      logic [OPW-1:0] op;
   } req_t;

   state_t        state;
   logic          last_grant;
   logic [CW-1:0] cnt;
   logic          iss_id;
   req_t          iss;
   req_t          gnt_req;
   logic          gnt_vld;
   logic          gnt_id;

   // Contention goes to whichever requester was not served last.
   assign gnt_vld    = req0_valid | req1_valid;
   assign gnt_id     = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
   assign gnt_req    = gnt_id ? {req1_a, req1_b, req1_op} : {req0_a, req0_b, req0_op};
   assign req0_ready = (state == IDLE) && gnt_vld && !gnt_id;
   assign req1_ready = (state == IDLE) && gnt_vld && gnt_id;
   assign busy       = (state != IDLE);

   assign alu_a  = iss.a;
   assign alu_b  = iss.b;
   assign alu_op = iss.op;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         cnt        <= '0;
         iss_id     <= 1'b0;
         iss        <= '0;
         alu_en     <= 1'b0;
         resp_valid <= 1'b0;
         resp_id    <= 1'b0;
         resp_res   <= '0;
         resp_flags <= '0;
      end else begin
         alu_en <= 1'b0;
         case (state)
            IDLE: if (gnt_vld) begin
               iss    <= gnt_req;
               iss_id <= gnt_id;
               alu_en <= 1'b1;
               state  <= ISSUE;
            end
            ISSUE: begin
               cnt   <= CW'(ALU_LAT - 1);
               state <= WAIT;
            end
            // The ALU result is only trusted on the final wait cycle.
            WAIT: if (cnt == '0) begin
               resp_res   <= alu_res;
               resp_flags <= {alu_c_out, alu_zero, alu_ovf};
               resp_id    <= iss_id;
               resp_valid <= 1'b1;
               state      <= RESP;
            end else begin
               cnt <= cnt - 1'b1;
            end
            RESP: if (resp_ready) begin
               resp_valid <= 1'b0;
               last_grant <= resp_id;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef ALU_ARB_STATS_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         op_cnt    <= '0;
         stall_cnt <= '0;
      end else begin
         if (state == RESP && resp_ready && op_cnt != 16'hFFFF)
            op_cnt <= op_cnt + 16'd1;
         if ((req0_valid || req1_valid) && state != IDLE && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
      end
   end
`endif

endmodule
